nmi_event_scheduler: RTL and testbench

- Collects NMI trigger requests from up to NSRC sources: hotkeys, joystick combo, external button, DivMMC/Multiface requests.
- Masks them, queues them and hands them one at a time, in priority order, to the NMI event block as a one-cycle one-hot userevents pulse.
- Issues nothing while the config ROM is paged in. Enforces a hold-off gap between services and a watchdog on unacknowledged issues.
- Sits between the input/keyboard logic and the NMI event block. Exposes a mask/status register on the ZX-Uno register bus.

---
 rtl/nmi_event_scheduler.sv | 125 ++++++++++++
 tb/tb_nmi_event_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nmi_event_scheduler.sv
// NMI request scheduler: captures request edges, queues them with a mask,
// and issues one-hot userevents pulses in priority order with ack watchdog
// and hold-off between services.
module nmi_event_scheduler #(
  parameter int unsigned NSRC    = 5,
  parameter logic [7:0]  REGADDR = 8'h0E,
  parameter int unsigned HOLDOFF = 16,
  parameter int unsigned TIMEOUT = 1048576
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] req,
  input  logic            page_configrom_active,
  input  logic [7:0]      zxuno_addr,
  input  logic            zxuno_regrd,
  input  logic            zxuno_regwr,
  input  logic [7:0]      din,
  output logic [7:0]      dout,
  output logic            oe_n,
  output logic [NSRC-1:0] userevents,
  output logic            busy
);

  localparam int unsigned CNT_MAX = (TIMEOUT > HOLDOFF) ? TIMEOUT : HOLDOFF;
  localparam int unsigned CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] HO_LAST = CW'(HOLDOFF - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACK, S_SERVICE, S_HOLDOFF
  } state_t;

  state_t          state, state_nx;
  logic [NSRC-1:0] pending, mask, grant, req_prev;
  logic [NSRC-1:0] rise, avail, pick, clear_c;
  logic            timeout_flag;
  logic [CW-1:0]   counter;
  logic            reg_wr;
  logic            grant_ld_c, issue_c, cnt_clr_c, cnt_inc_c, to_set_c;
  logic            unused_din;

  assign rise       = req & ~req_prev;
  assign avail      = pending & mask;
  // Isolate the lowest set bit: bit 0 has highest priority.
  assign pick       = avail & (~avail + NSRC'(1));
  assign reg_wr     = (zxuno_addr == REGADDR) && zxuno_regwr;
  assign oe_n       = !((zxuno_addr == REGADDR) && zxuno_regrd);
  assign dout       = {timeout_flag, 2'b00, 5'(pending)};
  assign unused_din = ^din[6:NSRC];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:     if (avail != '0 && !page_configrom_active) state_nx = S_ISSUE;
      S_ISSUE:    state_nx = S_WAIT_ACK;
      S_WAIT_ACK: if (page_configrom_active)  state_nx = S_SERVICE;
                  else if (counter == TO_LAST) state_nx = S_HOLDOFF;
      S_SERVICE:  if (!page_configrom_active) state_nx = S_HOLDOFF;
      S_HOLDOFF:  if (counter == HO_LAST)     state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // Per-state control strobes for the datapath.
  always_comb begin
    grant_ld_c = 1'b0;
    issue_c    = 1'b0;
    cnt_clr_c  = 1'b0;
    cnt_inc_c  = 1'b0;
    to_set_c   = 1'b0;
    unique case (state)
      S_IDLE:     grant_ld_c = (state_nx == S_ISSUE);
      S_ISSUE: begin
        issue_c   = 1'b1;
        cnt_clr_c = 1'b1;
      end
      S_WAIT_ACK: if (!page_configrom_active) begin
        cnt_inc_c = 1'b1;
        if (counter == TO_LAST) begin
          to_set_c  = 1'b1;
          cnt_clr_c = 1'b1;
        end
      end
      S_SERVICE:  cnt_clr_c = !page_configrom_active;
      S_HOLDOFF:  cnt_inc_c = 1'b1;
      default:    cnt_clr_c = 1'b0;
    endcase
  end

  assign clear_c = issue_c ? grant : '0;

  // Edge capture, pending queue, mask/status register, counter and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_prev     <= '1;
      pending      <= '0;
      mask         <= '1;
      grant        <= '0;
      timeout_flag <= 1'b0;
      counter      <= '0;
      userevents   <= '0;
      busy         <= 1'b0;
    end else begin
      req_prev <= req;
      // A new edge wins over the issue clear so a re-request is re-queued.
      pending  <= (pending & ~clear_c) | (rise & mask);
      if (reg_wr) mask <= din[NSRC-1:0];
      if (to_set_c)                 timeout_flag <= 1'b1;
      else if (reg_wr && din[7])    timeout_flag <= 1'b0;
      if (grant_ld_c) grant <= pick;
      if (cnt_clr_c)      counter <= '0;
      else if (cnt_inc_c) counter <= counter + CW'(1);
      userevents <= clear_c;
      busy       <= (state_nx != S_IDLE);
    end
  end

endmodule

// File: tb/tb_nmi_event_scheduler.sv
// Bench for nmi_event_scheduler: register/edge vector table, directed
// multi-cycle sequences, then random requests against a timeline model.
module tb_nmi_event_scheduler;

  localparam int unsigned HOLD = 16;
  localparam int unsigned TMO  = 64;
  localparam int          NCYC = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req;
  logic       page;
  logic [7:0] addr;
  logic       rd;
  logic       wr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       oe_n;
  logic [4:0] ue;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;
  int stray  = 0;

  always #5 clk = ~clk;

  nmi_event_scheduler #(
    .NSRC(5), .REGADDR(8'h0E), .HOLDOFF(HOLD), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .page_configrom_active(page),
    .zxuno_addr(addr), .zxuno_regrd(rd), .zxuno_regwr(wr), .din(din),
    .dout(dout), .oe_n(oe_n), .userevents(ue), .busy(busy)
  );

  typedef struct packed {
    logic [4:0] req;
    logic [7:0] addr;
    logic       rd;
    logic       wr;
    logic [7:0] din;
    logic [7:0] e_dout;
    logic       e_oe_n;
    logic [4:0] e_ue;
    logic       e_busy;
  } vec_t;

  vec_t vt [0:10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ue !== 5'h00) stray++;
  endtask

  task automatic wait_pulse(input string nm, input logic [4:0] exp, input int maxc);
    logic [4:0] got;
    got = '0;
    for (int i = 0; i < maxc && got == '0; i++) begin
      @(posedge clk);
      #1;
      got = ue;
    end
    chk(nm, 32'(got), 32'(exp));
  endtask

  // Ack the issue just seen, hold page for `hold` cycles, then run hold-off.
  task automatic serve(input int hold);
    tick();
    page = 1'b1;
    repeat (hold) tick();
    page = 1'b0;
    tick();
    repeat (HOLD) tick();
  endtask

  function automatic logic [4:0] first_of(input logic [4:0] v);
    for (int i = 0; i < 5; i++)
      if (v[i]) return 5'(1 << i);
    return '0;
  endfunction

  initial begin
    vt[0]  = '{5'h00, 8'h0E, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 5'h00, 1'b0};
    vt[1]  = '{5'h00, 8'h0E, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 5'h00, 1'b0};
    vt[2]  = '{5'h1F, 8'h0E, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 5'h00, 1'b0};
    vt[3]  = '{5'h00, 8'h0E, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 5'h00, 1'b0};
    vt[4]  = '{5'h00, 8'h0D, 1'b0, 1'b1, 8'h1F, 8'h00, 1'b1, 5'h00, 1'b0};
    vt[5]  = '{5'h0A, 8'h0E, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 5'h00, 1'b0};
    vt[6]  = '{5'h00, 8'h0E, 1'b0, 1'b1, 8'h1F, 8'h00, 1'b1, 5'h00, 1'b0};
    vt[7]  = '{5'h04, 8'h0E, 1'b1, 1'b0, 8'h00, 8'h04, 1'b0, 5'h00, 1'b0};
    vt[8]  = '{5'h04, 8'h0D, 1'b1, 1'b0, 8'h00, 8'h04, 1'b1, 5'h00, 1'b1};
    vt[9]  = '{5'h00, 8'h0E, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 5'h04, 1'b1};
    vt[10] = '{5'h00, 8'h0E, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 5'h00, 1'b1};

    rst = 1'b1; req = '0; page = 1'b0; addr = 8'h0E; rd = 1'b1; wr = 1'b0; din = '0;
    tick();
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset ue", 32'(ue), 32'h0);
    chk("reset dout", 32'(dout), 32'h00);
    rst = 1'b0;

    // Register access, masking and single-request vectors.
    for (int i = 0; i < 11; i++) begin
      req = vt[i].req; addr = vt[i].addr; rd = vt[i].rd; wr = vt[i].wr; din = vt[i].din;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d dout", i), 32'(dout), 32'(vt[i].e_dout));
      chk($sformatf("vec%0d oe_n", i), 32'(oe_n), 32'(vt[i].e_oe_n));
      chk($sformatf("vec%0d ue", i), 32'(ue), 32'(vt[i].e_ue));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vt[i].e_busy));
    end
    addr = 8'h0E; rd = 1'b1; wr = 1'b0;

    // Single request: ack 2 cycles after the pulse, drop 50 later.
    stray = 0;
    page = 1'b1;
    tick();
    repeat (49) tick();
    chk("svc busy", 32'(busy), 32'h1);
    page = 1'b0;
    tick();
    for (int k = 1; k <= HOLD; k++) begin
      tick();
      if (k == HOLD - 1) chk("holdoff busy hi", 32'(busy), 32'h1);
      if (k == HOLD)     chk("holdoff busy lo", 32'(busy), 32'h0);
    end
    chk("single pending", 32'(dout), 32'h00);
    chk("single stray", 32'(stray), 32'h0);

    // Priority: sources 4 and 1 rise together.
    req = 5'h12;
    tick();
    chk("prio pending", 32'(dout), 32'h12);
    wait_pulse("prio first", 5'h02, 5);
    stray = 0;
    serve(3);
    wait_pulse("prio second", 5'h10, 6);
    chk("prio between", 32'(stray), 32'h0);
    serve(3);

    // Masking: masked edge dropped, unmasked edge issued.
    req = '0; wr = 1'b1; din = 8'h1E;
    tick();
    wr = 1'b0; req = 5'h01; stray = 0;
    repeat (6) tick();
    chk("mask drop pending", 32'(dout), 32'h00);
    chk("mask drop pulse", 32'(stray), 32'h0);
    wr = 1'b1; din = 8'h1F;
    tick();
    wr = 1'b0; req = '0;
    tick();
    req = 5'h01;
    wait_pulse("mask open", 5'h01, 5);
    serve(2);

    // Re-request of source 3 in its own ISSUE cycle.
    req = 5'h08;
    tick();
    req = 5'h00;
    tick();
    req = 5'h08;
    @(posedge clk);
    #1;
    chk("rereq pulse", 32'(ue), 32'h08);
    chk("rereq pending", 32'(dout), 32'h08);
    serve(2);
    wait_pulse("rereq again", 5'h08, 5);
    serve(2);

    // Watchdog: no ack at all.
    req = '0;
    tick();
    req = 5'h01;
    wait_pulse("tmo pulse", 5'h01, 5);
    repeat (TMO - 1) tick();
    chk("tmo early", 32'(dout[7]), 32'h0);
    tick();
    chk("tmo flag", 32'(dout), 32'h80);
    repeat (HOLD) tick();
    chk("tmo idle", 32'(busy), 32'h0);
    wr = 1'b1; din = 8'h9F;
    tick();
    wr = 1'b0;
    chk("tmo clear", 32'(dout), 32'h00);

    // Reset while in SERVICE with source 3 pending.
    req = '0;
    tick();
    req = 5'h01;
    wait_pulse("rst pulse", 5'h01, 5);
    req = 5'h09;
    tick();
    page = 1'b1;
    tick();
    chk("pre-rst pending", 32'(dout), 32'h08);
    rst = 1'b1;
    tick();
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst ue", 32'(ue), 32'h0);
    chk("rst dout", 32'(dout), 32'h00);
    rst = 1'b0; page = 1'b0; stray = 0;
    repeat (10) tick();
    chk("held req no pulse", 32'(stray), 32'h0);
    req = '0;
    tick();
    req = 5'h08;
    wait_pulse("post-rst mask", 5'h08, 5);
    serve(2);

    // Random requests against a timeline model of issue/ack/hold-off.
    begin
      logic [4:0] m_prev, m_pend, m_mask, m_g, avail, rise, clr, e_ue;
      int iss_e, d, h, idle_from;
      bit have, e_busy;
      rst = 1'b1; req = '0; page = 1'b0; wr = 1'b0;
      tick();
      rst = 1'b0;
      m_prev = '1; m_pend = '0; m_mask = '1; m_g = '0;
      iss_e = -10; d = 1; h = 1; idle_from = 0; have = 1'b0;
      for (int n = 0; n < NCYC; n++) begin
        for (int b = 0; b < 5; b++)
          if ($urandom_range(7) == 0) req[b] = ~req[b];
        wr = ($urandom_range(40) == 0);
        din = {1'($urandom_range(1)), 2'b00, 5'($urandom_range(31)) | 5'h11};
        page = have && (n >= iss_e + 1 + d) && (n <= iss_e + d + h);
        @(posedge clk);
        #1;
        avail = m_pend & m_mask;
        rise  = req & ~m_prev;
        m_prev = req;
        clr = (have && n == iss_e + 1) ? m_g : 5'h00;
        m_pend = (m_pend & ~clr) | (rise & m_mask);
        if (n >= idle_from && avail != '0 && !page) begin
          have = 1'b1;
          iss_e = n;
          m_g = first_of(avail);
          d = $urandom_range(4, 1);
          h = $urandom_range(8, 1);
          idle_from = n + d + h + 18;
        end
        if (wr) m_mask = din[4:0];
        e_ue   = (have && n == iss_e + 1) ? m_g : 5'h00;
        e_busy = have && (n >= iss_e) && (n <= idle_from - 2);
        chk($sformatf("rand%0d ue", n), 32'(ue), 32'(e_ue));
        chk($sformatf("rand%0d busy", n), 32'(busy), 32'(e_busy));
        chk($sformatf("rand%0d dout", n), 32'(dout), 32'({3'b000, m_pend}));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
